nibble_serial_adder: RTL and testbench
======================================

// Module: nibble_serial_adder
// PURPOSE
//   Sequencer that sits directly upstream and downstream of the 4-bit ripple adder.
//   It adds two WIDTH-bit operands one nibble per cycle through a single 4-bit adder.
//   It presents one nibble pair plus the registered carry to the adder. It then
//   captures the 4-bit sum and carry-out and rebuilds the wide result.
//   The adder stays purely combinational; this block owns all state.
// PARAMETERS
//   NIBBLES   4   number of 4-bit slices; WIDTH = 4*NIBBLES (must be >= 1)
// PORTS
//   clk        in   1      single clock, rising edge
//   rst_n      in   1      asynchronous, active-low reset
//   start      in   1      request; accepted only in IDLE
//   a_in       in   WIDTH  operand A, sampled on accepted start
//   b_in       in   WIDTH  operand B, sampled on accepted start
//   cin_in     in   1      initial carry, sampled on accepted start
//   busy       out  1      high in RUN and DONE
//   done       out  1      one-cycle pulse; sum_out/cout_out valid
//   sum_out    out  WIDTH  result, held until next accepted start
//   cout_out   out  1      final carry, held with sum_out
//   add_a      out  4      to adder a3..a0 (bit i -> ai)
//   add_b      out  4      to adder b3..b0
//   add_cin    out  1      to adder cin0
//   add_s      in   4      from adder s3..s0
//   add_cout   in   1      from adder cout
// BEHAVIOUR
//   States: IDLE -> RUN -> DONE -> IDLE. Encoding is free; no illegal-state lockup (default -> IDLE).
//   Reset (async, rst_n=0): state=IDLE, counter=0, operand/sum regs=0, carry=0.
//     All outputs read 0 during and after reset. Reset mid-RUN aborts the op; no done pulse is issued.
//   IDLE: on an edge with start=1, load a_sh<=a_in, b_sh<=b_in, carry<=cin_in, cnt<=0.
//     Clear sum_out/cout_out to 0 and go to RUN.
//   RUN, each edge (slice k=cnt, k=0..NIBBLES-1):
//     the sum register shifts right by 4 and inserts add_s at bits [WIDTH-1:WIDTH-4];
//     carry<=add_cout; a_sh and b_sh shift right by 4; cnt<=cnt+1.
//     When k==NIBBLES-1: cout_out<=add_cout and go to DONE.
//   Adder drive: in RUN, add_a=a_sh[3:0], add_b=b_sh[3:0], add_cin=carry.
//     In IDLE and DONE, add_a=add_b=0 and add_cin=0.
//   DONE: done=1 for exactly this cycle, then go to IDLE unconditionally.
//   Latency: start accepted at edge E0; done is high in the cycle after edge E(NIBBLES).
//     That is NIBBLES+1 cycles start-to-done. Throughput is one op per NIBBLES+2 cycles.
//   start in RUN or DONE is ignored; it is not queued. The operand inputs are don't-care outside acceptance.
//   The counter is $clog2(NIBBLES)+1 bits wide and never wraps within an op.
//   Arithmetic: {cout_out,sum_out} = a_in + b_in + cin_in, exact, modulo 2^(WIDTH+1).
//   NIBBLES=1: RUN lasts one cycle; the result equals a single adder pass.
// TESTING
//   1) 0xFFFF + 0x0001, cin=0 -> done 5 cycles after start; sum_out=0x0000, cout_out=1.
//      The carry must ripple through all four slices.
//   2) 0x1234 + 0x4321, cin=1 -> sum_out=0x5556, cout_out=0.
//      add_a must sequence 4,3,2,1 in RUN cycles 1..4.
//   3) start held high continuously, ops 0x0F0F+0x00F1 then 0x8000+0x8000.
//      -> Second op is accepted only in the IDLE cycle after done.
//      -> Results are 0x1000/0 and 0x0000/1. Start in RUN/DONE is ignored.
//   4) rst_n pulsed low mid-RUN (after 2 slices).
//      -> Outputs go to 0 immediately and no done pulse appears.
//      -> A next op of 0x0001+0x0001 gives 0x0002.
//   5) NIBBLES=1 build: 0xF + 0x1, cin=1 -> sum_out=0x1, cout_out=1, done 2 cycles after start.
//   6) 1000 random operands/cin vs a reference model, with a live ripple adder instance in the loop.
//      -> All results exact; done is always a one-cycle pulse.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - Nibble-serial WIDTH-bit adder sequencer around an external 4-bit ripple adder
// Owns operand shifters, carry, slice counter and result rebuild; the adder itself stays combinational.
module nibble_serial_adder #(
    parameter int NIBBLES = 4,
    localparam int WIDTH = 4 * NIBBLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             cin_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic             cout_out,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_s,
    input  logic             add_cout
);

    localparam int CW = $clog2(NIBBLES) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             last_slice;

    assign last_slice = (cnt_q == CW'(NIBBLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last_slice) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        add_a   = 4'd0;
        add_b   = 4'd0;
        add_cin = 1'b0;
        case (state_q)
            S_RUN: begin
                busy    = 1'b1;
                add_a   = a_sh_q[3:0];
                add_b   = b_sh_q[3:0];
                add_cin = carry_q;
            end
            S_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: each RUN slice consumes the low nibble and inserts the sum nibble at the top.
    always_comb begin
        cnt_d   = cnt_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        if (state_q == S_IDLE && start) begin
            a_sh_d  = a_in;
            b_sh_d  = b_in;
            carry_d = cin_in;
            cnt_d   = '0;
            sum_d   = '0;
            cout_d  = 1'b0;
        end else if (state_q == S_RUN) begin
            sum_d   = (sum_q >> 4) | (WIDTH'(add_s) << (WIDTH - 4));
            carry_d = add_cout;
            a_sh_d  = a_sh_q >> 4;
            b_sh_d  = b_sh_q >> 4;
            cnt_d   = cnt_q + CW'(1);
            if (last_slice) cout_d = add_cout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    assign sum_out  = sum_q;
    assign cout_out = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - Self-checking bench for nibble_serial_adder
// A 4-bit adder is modelled in the loop; expected results come from plain wide arithmetic.
module tb_nibble_serial_adder;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, start, cin_in;
    logic [W-1:0] a_in, b_in;
    logic         busy, done, cout_out, add_cin, add_cout;
    logic [W-1:0] sum_out;
    logic [3:0]   add_a, add_b, add_s;

    logic         start1, cin1, busy1, done1, cout1, add_cin1, add_cout1;
    logic [3:0]   a1, b1, sum1, add_a1, add_b1, add_s1;

    assign {add_cout, add_s}   = 5'(add_a) + 5'(add_b) + 5'(add_cin);
    assign {add_cout1, add_s1} = 5'(add_a1) + 5'(add_b1) + 5'(add_cin1);

    nibble_serial_adder #(.NIBBLES(N)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in), .cin_in(cin_in),
        .busy(busy), .done(done), .sum_out(sum_out), .cout_out(cout_out),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_s(add_s), .add_cout(add_cout)
    );

    nibble_serial_adder #(.NIBBLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a_in(a1), .b_in(b1), .cin_in(cin1),
        .busy(busy1), .done(done1), .sum_out(sum1), .cout_out(cout1),
        .add_a(add_a1), .add_b(add_b1), .add_cin(add_cin1), .add_s(add_s1), .add_cout(add_cout1)
    );

    int total = 0;
    int bad   = 0;

    logic [3:0] aseq [0:31];
    int         aseq_n;

    // Launches one op at the current negedge and waits (bounded) for done.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input bit hold_start, output int lat,
                          output logic [W-1:0] s, output logic co);
        bit seen = 0;
        a_in = a; b_in = b; cin_in = c; start = 1'b1;
        lat = 0; aseq_n = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (!hold_start) start = 1'b0;
            if (busy && !done && aseq_n < 32) begin
                aseq[aseq_n] = add_a;
                aseq_n++;
            end
            if (done) seen = 1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL done_timeout: actual no done within 20 cycles, required done");
        end
        s = sum_out; co = cout_out;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; a_in = '0; b_in = '0; cin_in = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({busy, done, sum_out, cout_out, add_a, add_b, add_cin} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: actual busy=%b done=%b sum=%h cout=%b add_a=%h, required all 0",
                     busy, done, sum_out, cout_out, add_a);
        end
        total++;
        if ({busy1, done1, sum1, cout1, add_a1, add_b1, add_cin1} !== '0) begin
            bad++;
            $display("FAIL reset_outputs_n1: actual busy=%b done=%b sum=%h, required all 0", busy1, done1, sum1);
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({busy, done, sum_out, cout_out} !== '0) begin
            bad++;
            $display("FAIL after_reset_idle: actual busy=%b done=%b sum=%h, required 0", busy, done, sum_out);
        end
    endtask

    task automatic test_ripple();
        int lat; logic [W-1:0] s; logic co;
        run_op(16'hFFFF, 16'h0001, 1'b0, 0, lat, s, co);
        total++;
        if (lat !== N + 1) begin
            bad++;
            $display("FAIL ripple_latency: actual %0d, required %0d", lat, N + 1);
        end
        total++;
        if ({co, s} !== {1'b1, 16'h0000}) begin
            bad++;
            $display("FAIL ripple_result: actual %b/%h, required 1/0000", co, s);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || sum_out !== 16'h0000 || cout_out !== 1'b1) begin
            bad++;
            $display("FAIL ripple_hold: actual done=%b busy=%b sum=%h cout=%b, required 0/0/0000/1",
                     done, busy, sum_out, cout_out);
        end
    endtask

    task automatic test_sequence();
        int lat; logic [W-1:0] s; logic co;
        logic [W-1:0] a;
        a = 16'h1234;
        run_op(a, 16'h4321, 1'b1, 0, lat, s, co);
        total++;
        if ({co, s} !== {1'b0, 16'h5556}) begin
            bad++;
            $display("FAIL seq_result: actual %b/%h, required 0/5556", co, s);
        end
        total++;
        if (aseq_n !== N) begin
            bad++;
            $display("FAIL seq_run_cycles: actual %0d, required %0d", aseq_n, N);
        end else begin
            for (int k = 0; k < N; k++) begin
                total++;
                if (aseq[k] !== a[4*k +: 4]) begin
                    bad++;
                    $display("FAIL seq_add_a[%0d]: actual %h, required %h", k, aseq[k], a[4*k +: 4]);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat; logic [W-1:0] s; logic co;
        run_op(16'h0F0F, 16'h00F1, 1'b0, 1, lat, s, co);
        total++;
        if (lat !== N + 1 || {co, s} !== {1'b0, 16'h1000}) begin
            bad++;
            $display("FAIL b2b_first: actual lat=%0d %b/%h, required lat=%0d 0/1000", lat, co, s, N + 1);
        end
        run_op(16'h8000, 16'h8000, 1'b0, 1, lat, s, co);
        start = 1'b0;
        total++;
        if (lat !== N + 2) begin
            bad++;
            $display("FAIL b2b_gap: actual %0d, required %0d", lat, N + 2);
        end
        total++;
        if ({co, s} !== {1'b1, 16'h0000}) begin
            bad++;
            $display("FAIL b2b_second: actual %b/%h, required 1/0000", co, s);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_run();
        int lat; int pulses; logic [W-1:0] s; logic co;
        a_in = 16'hABCD; b_in = 16'h1111; cin_in = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, sum_out, cout_out, add_a, add_b, add_cin} !== '0) begin
            bad++;
            $display("FAIL midrun_reset_outputs: actual busy=%b sum=%h add_a=%h, required 0", busy, sum_out, add_a);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) pulses++;
        end
        total++;
        if (pulses !== 0) begin
            bad++;
            $display("FAIL midrun_no_done: actual %0d pulses, required 0", pulses);
        end
        run_op(16'h0001, 16'h0001, 1'b0, 0, lat, s, co);
        total++;
        if ({co, s} !== {1'b0, 16'h0002}) begin
            bad++;
            $display("FAIL midrun_next_op: actual %b/%h, required 0/0002", co, s);
        end
        @(negedge clk);
    endtask

    task automatic test_single_nibble();
        int lat = 0; bit seen = 0;
        a1 = 4'hF; b1 = 4'h1; cin1 = 1'b1; start1 = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            lat++;
            start1 = 1'b0;
            if (done1) seen = 1;
        end
        total++;
        if (!seen || lat !== 2) begin
            bad++;
            $display("FAIL n1_latency: actual seen=%0d lat=%0d, required lat=2", seen, lat);
        end
        total++;
        if ({cout1, sum1} !== {1'b1, 4'h1}) begin
            bad++;
            $display("FAIL n1_result: actual %b/%h, required 1/1", cout1, sum1);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        int lat; logic [W-1:0] s, a, b; logic co, c;
        logic [W:0] expv;
        for (int n = 0; n < 1000; n++) begin
            a = W'($urandom); b = W'($urandom); c = 1'($urandom);
            expv = {1'b0, a} + {1'b0, b} + (W+1)'(c);
            run_op(a, b, c, 0, lat, s, co);
            total++;
            if ({co, s} !== expv || lat !== N + 1) begin
                bad++;
                $display("FAIL rand_op[%0d] %h+%h+%b: actual %b/%h lat=%0d, required %b/%h lat=%0d",
                         n, a, b, c, co, s, lat, expv[W], expv[W-1:0], N + 1);
            end
            @(negedge clk);
            total++;
            if (done !== 1'b0) begin
                bad++;
                $display("FAIL rand_done_pulse[%0d]: actual done=%b, required 0", n, done);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_ripple();
        test_sequence();
        test_back_to_back();
        test_reset_mid_run();
        test_single_nibble();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
